// File: rtl/mips32_pipe_fwd.sv
// Five-stage MIPS32-subset pipeline with EX operand forwarding, load-use interlock,
// EX-resolved branches with a two-bubble flush, and an optional stall-only RAW mode.
module mips32_pipe_fwd #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10,
  parameter int FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic [4:0]         dbg_raddr,
  output logic [XLEN-1:0]    dbg_rdata,
  output logic               retire_valid,
  output logic [IMEM_AW-1:0] retire_pc,
  output logic               halted
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_t;

  logic [XLEN-1:0]    rf [NREG];
  logic [IMEM_AW-1:0] pc;
  logic               halt_fetch, halt_q;

  logic               ifid_v;
  logic [31:0]        ifid_ir;
  logic [IMEM_AW-1:0] ifid_pc;

  logic               idex_v, idex_rr, idex_lw, idex_sw, idex_beqz, idex_bneqz, idex_hlt;
  alu_op_t            idex_op;
  logic [XLEN-1:0]    idex_a, idex_b, idex_imm;
  logic [RW-1:0]      idex_rs, idex_rt, idex_dest;
  logic [IMEM_AW-1:0] idex_pc;

  logic               exmem_v, exmem_lw, exmem_sw, exmem_hlt;
  logic [XLEN-1:0]    exmem_alu, exmem_sd;
  logic [RW-1:0]      exmem_dest;
  logic [IMEM_AW-1:0] exmem_pc;

  logic               memwb_v, memwb_hlt;
  logic [XLEN-1:0]    memwb_res;
  logic [RW-1:0]      memwb_dest;
  logic [IMEM_AW-1:0] memwb_pc;

  // ID decode
  logic [5:0]      opc;
  logic [RW-1:0]   id_rs, id_rt, id_rd, id_dest;
  logic            d_rr, d_ri, d_lw, d_sw, d_beqz, d_bneqz, d_hlt;
  alu_op_t         d_op;
  logic            id_uses_rs, id_uses_rt;
  logic [XLEN-1:0] id_imm, id_a, id_b;

  assign opc    = ifid_ir[31:26];
  assign id_rs  = ifid_ir[21 +: RW];
  assign id_rt  = ifid_ir[16 +: RW];
  assign id_rd  = ifid_ir[11 +: RW];
  assign id_imm = {{(XLEN-16){ifid_ir[15]}}, ifid_ir[15:0]};

  always_comb begin
    d_rr = 1'b0; d_ri = 1'b0; d_lw = 1'b0; d_sw = 1'b0;
    d_beqz = 1'b0; d_bneqz = 1'b0; d_hlt = 1'b0; d_op = ALU_ADD;
    case (opc)
      6'h00: begin d_rr = 1'b1; d_op = ALU_ADD; end
      6'h01: begin d_rr = 1'b1; d_op = ALU_SUB; end
      6'h02: begin d_rr = 1'b1; d_op = ALU_AND; end
      6'h03: begin d_rr = 1'b1; d_op = ALU_OR;  end
      6'h04: begin d_rr = 1'b1; d_op = ALU_SLT; end
      6'h05: begin d_rr = 1'b1; d_op = ALU_MUL; end
      6'h0a: begin d_ri = 1'b1; d_op = ALU_ADD; end
      6'h0b: begin d_ri = 1'b1; d_op = ALU_SUB; end
      6'h0c: begin d_ri = 1'b1; d_op = ALU_SLT; end
      6'h08: d_lw    = 1'b1;
      6'h09: d_sw    = 1'b1;
      6'h0d: d_bneqz = 1'b1;
      6'h0e: d_beqz  = 1'b1;
      default: d_hlt = 1'b1;
    endcase
  end

  // Non-writing instructions carry destination 0 so hazard and forward logic ignore them
  assign id_uses_rs = d_rr | d_ri | d_lw | d_sw | d_beqz | d_bneqz;
  assign id_uses_rt = d_rr | d_sw;
  assign id_dest    = d_rr ? id_rd : ((d_ri | d_lw) ? id_rt : '0);

  logic wb_we;
  assign wb_we = memwb_v && !memwb_hlt && !halt_q && (memwb_dest != '0);
  assign id_a  = (id_rs == '0) ? '0 : ((wb_we && memwb_dest == id_rs) ? memwb_res : rf[id_rs]);
  assign id_b  = (id_rt == '0) ? '0 : ((wb_we && memwb_dest == id_rt) ? memwb_res : rf[id_rt]);

  logic idex_hit, exmem_hit, stall, freeze;
  assign idex_hit  = idex_v && (idex_dest != '0) &&
                     ((id_uses_rs && idex_dest == id_rs) || (id_uses_rt && idex_dest == id_rt));
  assign exmem_hit = exmem_v && (exmem_dest != '0) &&
                     ((id_uses_rs && exmem_dest == id_rs) || (id_uses_rt && exmem_dest == id_rt));
  assign stall  = ifid_v && ((FWD_EN != 0) ? (idex_hit && idex_lw) : (idex_hit || exmem_hit));
  assign freeze = halt_fetch || (ifid_v && d_hlt);

  // EX: forwarding, ALU, branch resolution
  logic [XLEN-1:0]    fwd_a, fwd_b, opb, alu_y;
  logic               br_taken;
  logic [IMEM_AW-1:0] br_target;

  always_comb begin
    fwd_a = idex_a;
    fwd_b = idex_b;
    if (FWD_EN != 0) begin
      if (exmem_v && !exmem_lw && exmem_dest != '0 && exmem_dest == idex_rs) fwd_a = exmem_alu;
      else if (memwb_v && memwb_dest != '0 && memwb_dest == idex_rs)         fwd_a = memwb_res;
      if (exmem_v && !exmem_lw && exmem_dest != '0 && exmem_dest == idex_rt) fwd_b = exmem_alu;
      else if (memwb_v && memwb_dest != '0 && memwb_dest == idex_rt)         fwd_b = memwb_res;
    end
    opb = idex_rr ? fwd_b : idex_imm;
    case (idex_op)
      ALU_SUB: alu_y = fwd_a - opb;
      ALU_AND: alu_y = fwd_a & opb;
      ALU_OR:  alu_y = fwd_a | opb;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(opb))};
      ALU_MUL: alu_y = fwd_a * opb;
      default: alu_y = fwd_a + opb;
    endcase
  end

  assign br_taken  = idex_v && ((idex_beqz && fwd_a == '0) || (idex_bneqz && fwd_a != '0));
  assign br_target = idex_pc + IMEM_AW'(1) + idex_imm[IMEM_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0; halt_fetch <= 1'b0; halt_q <= 1'b0;
      ifid_v <= 1'b0; ifid_ir <= '0; ifid_pc <= '0;
      idex_v <= 1'b0; idex_rr <= 1'b0; idex_lw <= 1'b0; idex_sw <= 1'b0;
      idex_beqz <= 1'b0; idex_bneqz <= 1'b0; idex_hlt <= 1'b0; idex_op <= ALU_ADD;
      idex_a <= '0; idex_b <= '0; idex_imm <= '0;
      idex_rs <= '0; idex_rt <= '0; idex_dest <= '0; idex_pc <= '0;
      exmem_v <= 1'b0; exmem_lw <= 1'b0; exmem_sw <= 1'b0; exmem_hlt <= 1'b0;
      exmem_alu <= '0; exmem_sd <= '0; exmem_dest <= '0; exmem_pc <= '0;
      memwb_v <= 1'b0; memwb_hlt <= 1'b0; memwb_res <= '0; memwb_dest <= '0; memwb_pc <= '0;
    end else begin
      // Flush beats a load-use stall; a decoded HLT freezes fetch unless it is flushed
      if (br_taken) begin
        pc <= br_target; ifid_v <= 1'b0;
      end else if (stall) begin
        pc <= pc;
      end else if (freeze) begin
        ifid_v <= 1'b0;
      end else begin
        pc <= pc + IMEM_AW'(1); ifid_v <= 1'b1; ifid_ir <= imem_rdata; ifid_pc <= pc;
      end
      if (ifid_v && d_hlt && !br_taken) halt_fetch <= 1'b1;

      idex_v <= ifid_v && !stall && !br_taken;
      idex_rr <= d_rr; idex_lw <= d_lw; idex_sw <= d_sw;
      idex_beqz <= d_beqz; idex_bneqz <= d_bneqz; idex_hlt <= d_hlt; idex_op <= d_op;
      idex_a <= id_a; idex_b <= id_b; idex_imm <= id_imm;
      idex_rs <= id_rs; idex_rt <= id_rt; idex_dest <= id_dest; idex_pc <= ifid_pc;

      exmem_v <= idex_v; exmem_lw <= idex_lw; exmem_sw <= idex_sw; exmem_hlt <= idex_hlt;
      exmem_alu <= alu_y; exmem_sd <= fwd_b; exmem_dest <= idex_dest; exmem_pc <= idex_pc;

      memwb_v <= exmem_v; memwb_hlt <= exmem_hlt;
      memwb_res <= exmem_lw ? dmem_rdata : exmem_alu;
      memwb_dest <= exmem_dest; memwb_pc <= exmem_pc;

      if (memwb_v && memwb_hlt) halt_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_dest] <= memwb_res;
    end
  end

  assign imem_addr    = pc;
  assign dmem_addr    = exmem_alu[DMEM_AW-1:0];
  assign dmem_wdata   = exmem_sd;
  assign dmem_we      = exmem_v && exmem_sw && !halt_q;
  assign dbg_rdata    = (dbg_raddr[RW-1:0] == '0) ? '0 : rf[dbg_raddr[RW-1:0]];
  assign retire_valid = memwb_v && !memwb_hlt && !halt_q;
  assign retire_pc    = memwb_pc;
  assign halted       = halt_q || (memwb_v && memwb_hlt);
endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// Directed bench: runs each program on a forwarding core and a stall-only core side by side,
// checking registers via the debug port, memory contents and retire/halt timing.
module tb_mips32_pipe_fwd;
  localparam logic [5:0] OP_ADD = 6'h00, OP_LW = 6'h08, OP_SW = 6'h09, OP_ADDI = 6'h0a,
                         OP_SLTI = 6'h0c, OP_BNEQZ = 6'h0d, OP_BEQZ = 6'h0e;
  localparam logic [31:0] HLT = 32'hfc00_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] dbg_raddr = '0;
  always #5 clk = ~clk;

  logic [9:0]  imem_addr0, imem_addr1, dmem_addr0, dmem_addr1, retire_pc0, retire_pc1;
  logic [31:0] imem_rdata0, imem_rdata1, dmem_wdata0, dmem_wdata1, dmem_rdata0, dmem_rdata1;
  logic [31:0] dbg_rdata0, dbg_rdata1;
  logic        dmem_we0, dmem_we1, retire_valid0, retire_valid1, halted0, halted1;

  logic [31:0] imem0 [32];
  logic [31:0] imem1 [32];
  logic [31:0] dmem0 [16];
  logic [31:0] dmem1 [16];

  assign imem_rdata0 = imem0[imem_addr0[4:0]];
  assign imem_rdata1 = imem1[imem_addr1[4:0]];
  assign dmem_rdata0 = dmem0[dmem_addr0[3:0]];
  assign dmem_rdata1 = dmem1[dmem_addr1[3:0]];

  mips32_pipe_fwd #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
    .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0), .dmem_we(dmem_we0), .dmem_rdata(dmem_rdata0),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata0), .retire_valid(retire_valid0),
    .retire_pc(retire_pc0), .halted(halted0));

  mips32_pipe_fwd #(.FWD_EN(0)) u_stall (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1), .dmem_we(dmem_we1), .dmem_rdata(dmem_rdata1),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata1), .retire_valid(retire_valid1),
    .retire_pc(retire_pc1), .halted(halted1));

  // Data memory re-initialises (dmem[4]=7) whenever reset is held across an edge
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        dmem0[i] <= '0;
        dmem1[i] <= '0;
      end
      dmem0[4] <= 32'd7;
      dmem1[4] <= 32'd7;
    end else begin
      if (dmem_we0) dmem0[dmem_addr0[3:0]] <= dmem_wdata0;
      if (dmem_we1) dmem1[dmem_addr1[3:0]] <= dmem_wdata1;
    end
  end

  // Cycle n = n-th cycle after reset release; retire/halt cycles recorded per core
  int cyc;
  int ret_cyc0 [16];
  int ret_cyc1 [16];
  int nret0, nret1, halt_cyc0, halt_cyc1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        ret_cyc0[i] <= 0;
        ret_cyc1[i] <= 0;
      end
      nret0 <= 0; nret1 <= 0; halt_cyc0 <= 0; halt_cyc1 <= 0;
    end else begin
      if (retire_valid0) begin ret_cyc0[retire_pc0[3:0]] <= cyc + 1; nret0 <= nret0 + 1; end
      if (retire_valid1) begin ret_cyc1[retire_pc1[3:0]] <= cyc + 1; nret1 <= nret1 + 1; end
      if (halted0 && halt_cyc0 == 0) halt_cyc0 <= cyc + 1;
      if (halted1 && halt_cyc1 == 0) halt_cyc1 <= cyc + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_raddr = idx[4:0];
    #1;
    chk({tag, "/fwd"}, dbg_rdata0, exp);
    chk({tag, "/stall"}, dbg_rdata1, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [4:0] s, t;
    logic [15:0] i16;
    s = rs[4:0]; t = rt[4:0]; i16 = imm[15:0];
    return {op, s, t, i16};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) begin
      imem0[i] = HLT;
      imem1[i] = HLT;
    end
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    imem0[addr] = w;
    imem1[addr] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt();
    for (int i = 0; i < 80; i++) begin
      if (halted0 && halted1) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("halted/fwd", {31'd0, halted0}, 32'd1);
    chk("halted/stall", {31'd0, halted1}, 32'd1);
  endtask

  initial begin
    // Program 1: independent ADDIs feeding an ADD
    clear_imem();
    put(0, enc_i(OP_ADDI, 1, 0, 10));
    put(1, enc_i(OP_ADDI, 2, 0, 20));
    put(2, enc_r(OP_ADD, 3, 1, 2));
    do_reset();
    chk("rst_pc", {22'd0, imem_addr0}, 32'd0);
    chk("rst_retire", {31'd0, retire_valid0}, 32'd0);
    chk("rst_halted", {31'd0, halted0}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we0}, 32'd0);
    run_to_halt();
    chk_reg("p1_r1", 1, 32'd10);
    chk_reg("p1_r2", 2, 32'd20);
    chk_reg("p1_r3", 3, 32'd30);
    chk("p1_ret0", ret_cyc0[0], 32'd5);
    chk("p1_ret1", ret_cyc0[1], 32'd6);
    chk("p1_ret2", ret_cyc0[2], 32'd7);
    chk("p1_nret", nret0, 32'd3);
    chk("p1_halt", halt_cyc0, 32'd8);
    chk("p1_stall_ret2", ret_cyc1[2], 32'd9);
    chk("p1_stall_halt", halt_cyc1, 32'd10);

    // Program 2: load-use interlock
    clear_imem();
    put(0, enc_i(OP_ADDI, 1, 0, 4));
    put(1, enc_i(OP_LW, 4, 1, 0));
    put(2, enc_r(OP_ADD, 5, 4, 4));
    do_reset();
    run_to_halt();
    chk_reg("p2_r4", 4, 32'd7);
    chk_reg("p2_r5", 5, 32'd14);
    chk("p2_ret_lw", ret_cyc0[1], 32'd6);
    chk("p2_ret_add", ret_cyc0[2], 32'd8);

    // Program 3: taken BEQZ skips two ADDIs
    clear_imem();
    put(0, enc_i(OP_BEQZ, 0, 1, 2));
    put(1, enc_i(OP_ADDI, 6, 0, 1));
    put(2, enc_i(OP_ADDI, 7, 0, 1));
    put(3, enc_i(OP_ADDI, 8, 0, 9));
    do_reset();
    run_to_halt();
    chk_reg("p3_r6", 6, 32'd0);
    chk_reg("p3_r7", 7, 32'd0);
    chk_reg("p3_r8", 8, 32'd9);
    chk("p3_ret_br", ret_cyc0[0], 32'd5);
    chk("p3_ret_skip", ret_cyc0[1], 32'd0);
    chk("p3_ret_r8", ret_cyc0[3], 32'd8);
    chk("p3_nret", nret0, 32'd2);

    // Program 4: not-taken BNEQZ, no penalty
    put(0, enc_i(OP_BNEQZ, 0, 1, 2));
    do_reset();
    run_to_halt();
    chk_reg("p4_r6", 6, 32'd1);
    chk_reg("p4_r7", 7, 32'd1);
    chk_reg("p4_r8", 8, 32'd9);
    chk("p4_ret1", ret_cyc0[1], 32'd6);
    chk("p4_nret", nret0, 32'd4);

    // Program 5: signed SLTI, R0 write discard, forwarded store data, store-then-load
    clear_imem();
    put(0, enc_i(OP_ADDI, 1, 0, -1));
    put(1, enc_i(OP_SLTI, 2, 1, 0));
    put(2, enc_i(OP_ADDI, 0, 0, 5));
    put(3, enc_i(OP_SW, 2, 0, 3));
    put(4, enc_i(OP_LW, 9, 0, 3));
    do_reset();
    run_to_halt();
    chk_reg("p5_r1", 1, 32'hffff_ffff);
    chk_reg("p5_r2", 2, 32'd1);
    chk_reg("p5_r0", 0, 32'd0);
    chk_reg("p5_r9", 9, 32'd1);
    chk("p5_dmem3/fwd", dmem0[3], 32'd1);
    chk("p5_dmem3/stall", dmem1[3], 32'd1);

    // Reset while halted, then again mid-program, then re-run to completion
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", {31'd0, halted0}, 32'd0);
    chk("rst2_pc", {22'd0, imem_addr0}, 32'd0);
    chk_reg("rst2_r2", 2, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_reg("mid_r1", 1, 32'hffff_ffff);
    rst_n = 1'b0;
    #1;
    chk_reg("mid_rst_r1", 1, 32'd0);
    chk("mid_rst_pc", {22'd0, imem_addr0}, 32'd0);
    chk("mid_rst_retire", {31'd0, retire_valid0}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_to_halt();
    chk_reg("rerun_r2", 2, 32'd1);
    chk_reg("rerun_r9", 9, 32'd1);
    chk("rerun_dmem3", dmem0[3], 32'd1);
    chk("rerun_halt", halt_cyc0, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips32_pipe_fwd.md
Name: mips32_pipe_fwd

Overview:
- Single-clock, 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset pipeline core. It is the successor to the team's two-phase pipelined core.
- Adds operand forwarding, load-use interlock, branch flush, parametrised data width and register count, and a forwarding-disable mode.
- Instruction and data memories are external.
- Sits under the SoC top; the testbench drives memories and reads registers through a debug port.

Parameters:
- XLEN, 32: datapath and register width. Instructions are always 32 bits.
- NREG, 32: number of architectural registers. Must be a power of 2, at most 32. Register fields use the low log2(NREG) bits.
- IMEM_AW, 10: instruction word-address width. PC wraps modulo 2^IMEM_AW.
- DMEM_AW, 10: data word-address width.
- FWD_EN, 1: 1 = forwarding enabled; 0 = RAW hazards resolved by ID stall.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  IMEM_AW  PC, word address
- imem_rdata  in  32  instruction at imem_addr, combinational
- dmem_addr  out  DMEM_AW  low bits of the MEM-stage ALU result
- dmem_wdata  out  XLEN  store data
- dmem_we  out  1  write strobe; memory writes at the clk edge
- dmem_rdata  in  XLEN  combinational read data
- dbg_raddr  in  5  debug register index
- dbg_rdata  out  XLEN  combinational register read; index 0 reads 0
- retire_valid  out  1  a non-bubble instruction completed WB this cycle
- retire_pc  out  IMEM_AW  PC of the retiring instruction
- halted  out  1  HLT has retired

Behaviour:
- ISA opcodes are unchanged from the team ISA:
  - ADD/SUB/AND/OR/SLT/MUL: rd = [15:11].
  - ADDI/SUBI/SLTI: rt = [20:16].
  - LW/SW, BEQZ/BNEQZ, HLT.
  - Any other opcode decodes as HLT.
- Immediate is sign-extended from bit 15 to XLEN.
- SLT/SLTI compare signed. MUL keeps the low XLEN bits. Arithmetic wraps modulo 2^XLEN.
- Reset (async, any time, including mid-operation):
  - PC=0; all stage registers are bubbles.
  - All registers 0; halted=0, retire_valid=0, dmem_we=0.
- Latency: an instruction fetched in cycle n with no stalls retires in cycle n+4.
- Register file:
  - Written at the WB edge.
  - A same-cycle ID read of the WB destination returns the new value (WB->ID bypass; present in both modes).
  - Writes to R0 are discarded.
- Forwarding (FWD_EN=1):
  - EX operands A and B take the value from EX/MEM (ALU types only) over MEM/WB (ALU or load) over the register file.
  - The youngest producer wins. A destination of 0 is never forwarded.
  - SW store data is forwarded by the same rule.
- Load-use: a LW in EX whose rt matches an rs/rt source of the instruction in ID (nonzero index) causes 1 stall:
  - PC and IF/ID hold.
  - A bubble is inserted into ID/EX.
- FWD_EN=0: ID stalls while any older in-flight instruction in EX or MEM has a nonzero destination equal to an ID source.
- Branches:
  - Resolved in EX. Taken when BEQZ and A==0, or BNEQZ and A!=0 (A forwarded).
  - Target = NPC + imm.
  - Taken: PC <= target; IF/ID and ID/EX are replaced by bubbles (2-cycle penalty). Not taken: no penalty.
  - A simultaneous load-use stall is overridden by the flush.
- HLT:
  - When decoded, fetch freezes: PC holds and IF injects bubbles.
  - Older instructions drain normally.
  - When HLT reaches WB: halted=1 (sticky until reset); no further register/memory writes and no retire_valid.
  - An HLT in the shadow of a taken branch is flushed and has no effect.
- dmem_we is asserted only for SW in MEM; bubbles never write.

Test Plan:
- FWD_EN=1: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; HLT -> R3=30, no stalls, retire_valid on cycles 5,6,7, halted on cycle 8.
- FWD_EN=0, same program -> R3=30 with exactly 2 stall cycles; ADD retires 2 cycles later than with FWD_EN=1.
- dmem[4]=7; ADDI R1,R0,4; LW R4,0(R1); ADD R5,R4,R4 -> R5=14, exactly 1 bubble between LW and ADD retire.
- R1=0; BEQZ R1,+2; ADDI R6,R0,1; ADDI R7,R0,1; ADDI R8,R0,9 -> R6=R7=0, R8=9, 2 bubbles. Repeat with BNEQZ -> R6=R7=1.
- ADDI R1,R0,-1; SLTI R2,R1,0; ADDI R0,R0,5; SW R2,3(R0); LW R9,3(R0) -> R2=1, R0 reads 0, dmem[3]=1, R9=1.
- Assert rst_n low mid-program, then release -> PC=0, registers 0, halted=0, and the program re-runs to the same final state.
